// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt/breakpoint controller for a simple in-order CPU.
// The core advances one instruction per clock while cpu_ena is high. One
// hardware breakpoint compares pc_in against a loaded address. The breakpointed
// instruction is held back, and it executes exactly once when execution resumes.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready. cmd_ready depends only on the current state and
// cmd_op, never on cmd_valid. While the core is executing (RUN/STEP), only
// HALT and SET_BP are accepted. RUN and STEP stall until the core is stopped.
module cpu_run_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    input  logic        bp_clr,
    input  logic [31:0] pc_in,
    output logic        cpu_ena,
    output logic [1:0]  state,
    output logic        bp_hit,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam logic [1:0] OP_RUN    = 2'b00;
    localparam logic [1:0] OP_STEP   = 2'b01;
    localparam logic [1:0] OP_HALT   = 2'b10;
    localparam logic [1:0] OP_SET_BP = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] step_cnt_q, step_cnt_d;
    logic [31:0] bp_addr_q, bp_addr_d;
    logic        bp_valid_q, bp_valid_d;
    logic        skip_flag_q, skip_flag_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    logic        executing;
    logic        bp_stop;
    logic        ena;
    logic        ready;
    logic        accept;
    logic        acc_run;
    logic        acc_step;
    logic        acc_halt;
    logic        acc_set_bp;

    // Execution enable, breakpoint detection and command acceptance
    always_comb begin
        executing  = (state_q == ST_RUN) || (state_q == ST_STEP);
        // A breakpoint stops only free-running execution. It is suppressed for
        // the first instruction after resuming from BREAK.
        bp_stop    = (state_q == ST_RUN) && bp_valid_q &&
                     (pc_in == bp_addr_q) && !skip_flag_q;
        ena        = executing && !bp_stop;
        ready      = !executing || (cmd_op == OP_HALT) || (cmd_op == OP_SET_BP);
        accept     = cmd_valid && ready;
        acc_run    = accept && (cmd_op == OP_RUN);
        acc_step   = accept && (cmd_op == OP_STEP);
        acc_halt   = accept && (cmd_op == OP_HALT);
        acc_set_bp = accept && (cmd_op == OP_SET_BP);
    end

    // Run-control FSM: next state, step budget and resume-skip flag
    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        skip_flag_d = skip_flag_q;

        // The first instruction retired after a resume consumes the skip.
        if (ena) begin
            skip_flag_d = 1'b0;
        end

        case (state_q)
            ST_HALT, ST_BREAK: begin
                if (acc_run) begin
                    state_d = ST_RUN;
                    if (state_q == ST_BREAK) begin
                        skip_flag_d = 1'b1;
                    end
                end else if (acc_step) begin
                    state_d    = ST_STEP;
                    step_cnt_d = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
                    if (state_q == ST_BREAK) begin
                        skip_flag_d = 1'b1;
                    end
                end else if (acc_halt) begin
                    state_d    = ST_HALT;
                    step_cnt_d = 32'd0;
                end
            end
            ST_RUN: begin
                // A HALT takes priority over a breakpoint match in the same
                // cycle. The core stops in HALT, not BREAK.
                if (acc_halt) begin
                    state_d    = ST_HALT;
                    step_cnt_d = 32'd0;
                end else if (bp_stop) begin
                    state_d = ST_BREAK;
                end
            end
            ST_STEP: begin
                // STEP always retires this cycle, even if a HALT arrives too.
                if (acc_halt) begin
                    state_d    = ST_HALT;
                    step_cnt_d = 32'd0;
                end else if (step_cnt_q <= 32'd1) begin
                    state_d    = ST_HALT;
                    step_cnt_d = 32'd0;
                end else begin
                    step_cnt_d = step_cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Breakpoint register: load or disable on an accepted SET_BP
    always_comb begin
        bp_addr_d  = bp_addr_q;
        bp_valid_d = bp_valid_q;
        if (acc_set_bp) begin
            if (bp_clr) begin
                bp_valid_d = 1'b0;
            end else begin
                bp_addr_d  = cmd_arg;
                bp_valid_d = 1'b1;
            end
        end
    end

    // Retired-instruction counter, free-running with natural wrap
    always_comb begin
        retired_cnt_d = retired_cnt_q + {31'd0, ena};
    end

    // State registers. The async reset also drops cpu_ena immediately through state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HALT;
            step_cnt_q    <= 32'd0;
            bp_addr_q     <= 32'd0;
            bp_valid_q    <= 1'b0;
            skip_flag_q   <= 1'b0;
            retired_cnt_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            bp_addr_q     <= bp_addr_d;
            bp_valid_q    <= bp_valid_d;
            skip_flag_q   <= skip_flag_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Output mapping
    always_comb begin
        cmd_ready   = ready;
        cpu_ena     = ena;
        state       = state_q;
        bp_hit      = (state_q == ST_BREAK);
        retired_cnt = retired_cnt_q;
    end

endmodule
